pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Power-up and recovery sequencer for the on-chip PLL primitive wrapper. It pulses the PLL reset and qualifies the asynchronous extlock output through a synchronizer and a stability window. It then releases per-clock-domain resets one at a time in a fixed order. If lock is lost, it re-acquires lock; if acquisition keeps failing, it stops in a fault state.

Parameters:
NUM_DOMAINS, 4, number of downstream domain resets (one per PLL output clock)
RST_HOLD_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in acquisition before a retry (>LOCK_STABLE_CYCLES)
MAX_RETRIES, 3, failed attempts tolerated before FAULT
RELEASE_GAP, 8, cycles between consecutive domain reset releases (>=1)

Ports:
refclk  input  1  free-running reference clock; all logic on rising edge
reset  input  1  synchronous, active-high block reset
restart  input  1  single-cycle pulse; forces a fresh acquisition from any state
extlock  input  1  PLL lock indication, asynchronous to refclk
pll_reset  output  1  drives PLL reset/dsm_rst, active-high
domain_rst  output  NUM_DOMAINS  per-domain active-high resets; bit 0 released first
locked  output  1  qualified lock, high from RELEASE entry until lock loss
fault  output  1  retries exhausted
retry_cnt  output  clog2(MAX_RETRIES+1)  failed attempts in the current acquisition

Behaviour:
- extlock passes through a 2-flop synchronizer to give lock_s, adding 2 cycles of latency. All decisions use lock_s.
- All outputs are registered.
- Reset value: state=PLL_RST, pll_reset=1, domain_rst=all 1, locked=0, fault=0, retry_cnt=0, all counters 0.
- PLL_RST: pll_reset=1 for exactly RST_HOLD_CYCLES cycles, then go to WAIT_LOCK. pll_reset=0 from that edge. Clear the timeout counter.
- WAIT_LOCK: the timeout counter increments every cycle.
  - If lock_s=1, go to STABLE with the stable counter=1.
  - If the timeout counter reaches LOCK_TIMEOUT_CYCLES-1 with no lock: when retry_cnt==MAX_RETRIES, go to FAULT; otherwise increment retry_cnt and go to PLL_RST.
- STABLE: the stable counter increments while lock_s=1. The timeout counter keeps running.
  - If lock_s=0, return to WAIT_LOCK and clear the stable counter.
  - If the timeout expires first, apply the same retry/FAULT rule as WAIT_LOCK.
  - When the stable counter reaches LOCK_STABLE_CYCLES, go to RELEASE. On that same edge: locked=1, domain_rst[0]=0, retry_cnt=0.
- RELEASE: domain_rst[i] deasserts RELEASE_GAP cycles after domain_rst[i-1]. When the last bit deasserts, go to RUN. Released bits stay low.
- RUN: steady state; all domain_rst=0.
- Lock loss (lock_s=0 in RELEASE or RUN): on the next edge, all domain_rst=1, locked=0, pll_reset=1, go to PLL_RST. retry_cnt starts at 0.
- FAULT: pll_reset=1, domain_rst=all 1, locked=0, fault=1. Leave only via reset or restart.
- restart from any state: next state is PLL_RST with retry_cnt=0, fault=0, locked=0, domain_rst=all 1.
- Simultaneous events: reset overrides restart; restart overrides lock loss and timeout; timeout and lock_s rising on the same cycle in WAIT_LOCK resolves as lock (go to STABLE).
- NUM_DOMAINS=1: RELEASE lasts zero extra cycles and goes straight to RUN.

Optional Feature:
PLL_LOCK_LOSS_CNT_EN. When defined, add output lock_loss_cnt [7:0]. It increments on each RELEASE/RUN→PLL_RST lock-loss transition, saturates at 255, and clears only on reset (not on restart). When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
Bench parameters for all scenarios: NUM_DOMAINS=4, RST_HOLD=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2, GAP=2.
1. Nominal acquisition: deassert reset at cycle 0, raise extlock at edge E=10 → pll_reset high cycles 0–3 and low from 4; locked and domain_rst[0] low at E+10; domain_rst[1..3] low at E+12, E+14, E+16.
2. Glitchy lock: extlock high for 5 cycles, low 1 cycle, then high → locked does not rise until 8 consecutive lock_s cycles after the glitch; domain_rst stays 4'b1111 until then.
3. Timeout/fault: extlock held 0 → three PLL_RST pulses with retry_cnt going 0,1,2; after the third timeout, fault=1, pll_reset=1, domain_rst=4'b1111, stable indefinitely.
4. Restart from FAULT: pulse restart → next cycle fault=0, retry_cnt=0, pll_reset high 4 cycles; with extlock=1 the scenario 1 timing is reproduced.
5. Lock loss in RUN: drop extlock → 3 cycles later domain_rst=4'b1111, locked=0, pll_reset=1; re-raise extlock and full re-release occurs. With PLL_LOCK_LOSS_CNT_EN, lock_loss_cnt=1.
6. Lock loss mid-RELEASE, with restart asserted on the same cycle lock_s falls → restart path taken; lock_loss_cnt unchanged, all domain resets reasserted.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses pll_reset, qualifies extlock, releases domain resets in order.
// Optional PLL_LOCK_LOSS_CNT_EN adds a saturating lock_loss_cnt output.
module pll_lock_sequencer #(
    parameter int unsigned NUM_DOMAINS         = 4,
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned RELEASE_GAP         = 8,
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                   refclk,
    input  logic                   reset,
    input  logic                   restart,
    input  logic                   extlock,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   locked,
    output logic                   fault,
    output logic [RETRY_W-1:0]     retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]             lock_loss_cnt
`endif
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(RELEASE_GAP + 1);

    localparam logic [NUM_DOMAINS-1:0] ALL_RST       = '1;
    localparam logic [NUM_DOMAINS-1:0] FIRST_RELEASE = ALL_RST << 1;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic [1:0]             sync_q;
    logic                   lock_s;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [STB_W-1:0]       stb_q, stb_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [RETRY_W-1:0]     retry_d;
    logic [NUM_DOMAINS-1:0] dom_d;
    logic [NUM_DOMAINS-1:0] dom_shift_c;
    logic                   locked_d, fault_d, pll_reset_d;
    logic                   start_c, fail_c, timeout_c;
    logic [TMO_W-1:0]       tmo_inc_c;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0]             loss_d;
`endif

    assign lock_s = sync_q[1];

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge refclk) begin
        if (reset) begin
            sync_q     <= 2'b00;
            state_q    <= S_PLL_RST;
            hold_q     <= '0;
            tmo_q      <= '0;
            stb_q      <= '0;
            gap_q      <= '0;
            retry_cnt  <= '0;
            domain_rst <= ALL_RST;
            locked     <= 1'b0;
            fault      <= 1'b0;
            pll_reset  <= 1'b1;
`ifdef PLL_LOCK_LOSS_CNT_EN
            lock_loss_cnt <= 8'd0;
`endif
        end else begin
            sync_q     <= {sync_q[0], extlock};
            state_q    <= state_d;
            hold_q     <= hold_d;
            tmo_q      <= tmo_d;
            stb_q      <= stb_d;
            gap_q      <= gap_d;
            retry_cnt  <= retry_d;
            domain_rst <= dom_d;
            locked     <= locked_d;
            fault      <= fault_d;
            pll_reset  <= pll_reset_d;
`ifdef PLL_LOCK_LOSS_CNT_EN
            lock_loss_cnt <= loss_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        tmo_d       = tmo_q;
        stb_d       = stb_q;
        gap_d       = gap_q;
        retry_d     = retry_cnt;
        dom_d       = domain_rst;
        locked_d    = locked;
        fault_d     = fault;
        pll_reset_d = pll_reset;
        start_c     = 1'b0;
        fail_c      = 1'b0;
        timeout_c   = (tmo_q >= TMO_W'(LOCK_TIMEOUT_CYCLES - 1));
        tmo_inc_c   = timeout_c ? tmo_q : tmo_q + TMO_W'(1);
        dom_shift_c = domain_rst << 1;
`ifdef PLL_LOCK_LOSS_CNT_EN
        loss_d      = lock_loss_cnt;
`endif

        if (restart) begin
            start_c = 1'b1;
            retry_d = '0;
            fault_d = 1'b0;
        end else if ((state_q == S_RELEASE || state_q == S_RUN) && !lock_s) begin
            start_c = 1'b1;
            retry_d = '0;
`ifdef PLL_LOCK_LOSS_CNT_EN
            if (lock_loss_cnt != 8'hFF) loss_d = lock_loss_cnt + 8'd1;
`endif
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (hold_q == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
                        state_d     = S_WAIT_LOCK;
                        pll_reset_d = 1'b0;
                        tmo_d       = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle wins over the timeout
                    if (lock_s) begin
                        state_d = S_STABLE;
                        stb_d   = STB_W'(1);
                        tmo_d   = tmo_inc_c;
                    end else if (timeout_c) begin
                        fail_c = 1'b1;
                    end else begin
                        tmo_d = tmo_inc_c;
                    end
                end
                S_STABLE: begin
                    if (lock_s && stb_q >= STB_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d  = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
                        locked_d = 1'b1;
                        dom_d    = FIRST_RELEASE;
                        retry_d  = '0;
                        gap_d    = '0;
                        stb_d    = '0;
                    end else if (timeout_c) begin
                        fail_c = 1'b1;
                    end else if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        stb_d   = '0;
                        tmo_d   = tmo_inc_c;
                    end else begin
                        stb_d = stb_q + STB_W'(1);
                        tmo_d = tmo_inc_c;
                    end
                end
                S_RELEASE: begin
                    // Released bits fill from bit 0 upward, so a left shift frees the next one
                    if (gap_q == GAP_W'(RELEASE_GAP - 1)) begin
                        gap_d = '0;
                        dom_d = dom_shift_c;
                        if (dom_shift_c == '0) state_d = S_RUN;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                S_RUN, S_FAULT: begin
                end
                default: begin
                    start_c = 1'b1;
                end
            endcase

            if (fail_c) begin
                if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
                    state_d     = S_FAULT;
                    pll_reset_d = 1'b1;
                    dom_d       = ALL_RST;
                    locked_d    = 1'b0;
                    fault_d     = 1'b1;
                end else begin
                    retry_d = retry_cnt + RETRY_W'(1);
                    start_c = 1'b1;
                end
            end
        end

        // Common entry into a fresh acquisition attempt
        if (start_c) begin
            state_d     = S_PLL_RST;
            hold_d      = '0;
            tmo_d       = '0;
            stb_d       = '0;
            gap_d       = '0;
            pll_reset_d = 1'b1;
            dom_d       = ALL_RST;
            locked_d    = 1'b0;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed test-plan scenarios, then randomized
// extlock/restart/reset stimulus against an age-based behavioural model.
module tb_pll_lock_sequencer;

    localparam int unsigned ND   = 4;
    localparam int unsigned HOLD = 4;
    localparam int unsigned STB  = 8;
    localparam int unsigned TMO  = 32;
    localparam int unsigned MAXR = 2;
    localparam int unsigned GAP  = 2;

    localparam int M_ACQ   = 0;
    localparam int M_REL   = 1;
    localparam int M_FAULT = 2;

    logic          refclk = 1'b0;
    logic          reset;
    logic          restart;
    logic          extlock;
    logic          pll_reset;
    logic [ND-1:0] domain_rst;
    logic          locked;
    logic          fault;
    logic [1:0]    retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0]    lock_loss_cnt;
`endif

    int n_tests;
    int n_fail;

    // Model: mode, cycles since attempt start, consecutive lock run, cycles since release start
    int m_mode, m_age, m_run, m_rel, m_retries, m_loss;
    bit m_s1, m_s2;

    pll_lock_sequencer #(
        .NUM_DOMAINS        (ND),
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_STABLE_CYCLES (STB),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES        (MAXR),
        .RELEASE_GAP        (GAP)
    ) dut (
        .refclk    (refclk),
        .reset     (reset),
        .restart   (restart),
        .extlock   (extlock),
        .pll_reset (pll_reset),
        .domain_rst(domain_rst),
        .locked    (locked),
        .fault     (fault),
        .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [ND-1:0] exp_dom();
        int n;
        if (m_mode != M_REL) return '1;
        n = 1 + m_rel / GAP;
        if (n > ND) n = ND;
        return ND'(((1 << ND) - 1) & ~((1 << n) - 1));
    endfunction

    task automatic new_attempt();
        m_mode = M_ACQ;
        m_age  = 0;
        m_run  = 0;
    endtask

    task automatic model_step(input bit rst, input bit rs, input bit ext);
        bit ls;
        int prev;
        ls = m_s2;
        if (rst) begin
            new_attempt();
            m_rel = 0; m_retries = 0; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = ext;
        if (rs) begin
            new_attempt();
            m_retries = 0;
            return;
        end
        if (m_mode == M_REL) begin
            if (!ls) begin
                new_attempt();
                m_retries = 0;
                if (m_loss < 255) m_loss++;
            end else if (m_rel < 1000) begin
                m_rel++;
            end
        end else if (m_mode == M_ACQ) begin
            if (m_age < HOLD) begin
                m_age++;
            end else begin
                prev = m_run;
                if (ls && prev > 0 && prev >= STB - 1) begin
                    m_mode = M_REL; m_rel = 0; m_retries = 0;
                end else if (ls && prev == 0) begin
                    m_run = 1; m_age++;
                end else if (m_age - HOLD >= TMO - 1) begin
                    if (m_retries == MAXR) m_mode = M_FAULT;
                    else begin m_retries++; new_attempt(); end
                end else begin
                    m_run = ls ? m_run + 1 : 0;
                    m_age++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step(reset, restart, extlock);
        #1;
        check("pll_reset", 32'(pll_reset), 32'((m_mode == M_FAULT) || (m_mode == M_ACQ && m_age < HOLD)));
        check("locked", 32'(locked), 32'(m_mode == M_REL));
        check("fault", 32'(fault), 32'(m_mode == M_FAULT));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retries));
        check("domain_rst", 32'(domain_rst), 32'(exp_dom()));
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
    endtask

    initial begin
        int n;
        int run_left;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; restart = 1'b0; extlock = 1'b0;
        repeat (3) tick();

        // Nominal acquisition
        reset = 1'b0;
        n = 0; while (pll_reset && n < 50) begin tick(); n++; end
        check("s1_hold_len", 32'(n), 32'd4);
        repeat (6) tick();
        extlock = 1'b1;
        n = 0; while (!locked && n < 100) begin tick(); n++; end
        check("s1_lock_lat", 32'(n), 32'd10);
        check("s1_first_release", 32'(domain_rst), 32'hE);
        n = 0; while (domain_rst != '0 && n < 100) begin tick(); n++; end
        check("s1_release_done", 32'(n), 32'd6);

        // Glitchy lock
        reset = 1'b1; extlock = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        extlock = 1'b1; repeat (5) tick();
        extlock = 1'b0; tick();
        extlock = 1'b1;
        n = 0; while (!locked && n < 100) begin tick(); n++; end
        check("s2_lock_lat", 32'(n), 32'd10);

        // Timeout to fault
        reset = 1'b1; extlock = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        n = 0; while (!fault && n < 300) begin tick(); n++; end
        check("s3_fault_lat", 32'(n), 32'd108);
        repeat (20) tick();
        check("s3_fault_hold", 32'(fault), 32'd1);

        // Restart from fault
        restart = 1'b1; extlock = 1'b1;
        tick();
        restart = 1'b0;
        check("s4_fault_clr", 32'(fault), 32'd0);
        n = 0; while (!locked && n < 100) begin tick(); n++; end
        check("s4_lock_lat", 32'(n), 32'd12);
        n = 0; while (domain_rst != '0 && n < 100) begin tick(); n++; end
        check("s4_release_done", 32'(n), 32'd6);

        // Lock loss in RUN
        extlock = 1'b0;
        n = 0; while (domain_rst != '1 && n < 50) begin tick(); n++; end
        check("s5_loss_lat", 32'(n), 32'd3);
        extlock = 1'b1;
        n = 0; while (domain_rst != '0 && n < 200) begin tick(); n++; end
        check("s5_rerelease", 32'(domain_rst), 32'd0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("s5_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif

        // Lock loss mid-release coinciding with restart
        restart = 1'b1; tick(); restart = 1'b0;
        n = 0; while (!locked && n < 200) begin tick(); n++; end
        check("s6_in_release", 32'(domain_rst), 32'hE);
        extlock = 1'b0;
        repeat (2) tick();
        restart = 1'b1; tick(); restart = 1'b0;
        check("s6_dom", 32'(domain_rst), 32'hF);
        check("s6_locked", 32'(locked), 32'd0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("s6_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif

        // Randomized stimulus
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                extlock  = ($urandom_range(0, 99) < 70);
                run_left = $urandom_range(1, 60);
            end
            run_left--;
            restart = ($urandom_range(0, 199) == 0);
            reset   = ($urandom_range(0, 999) == 0);
            tick();
        end
        restart = 1'b0; reset = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
